// File: rtl/upd7800_clkgen.sv
// Four-quarter clock-enable sequencer and phase-aligned reset stretcher
// feeding the uPD7800 core's CP1/CP2 enables and RESETB.
`timescale 1ns/1ps
module upd7800_clkgen #(
  parameter int DIV        = 1,
  parameter int RST_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       HOLD,
  input  logic       EXT_RESB,
  output logic       CP1_POSEDGE,
  output logic       CP1_NEGEDGE,
  output logic       CP2_POSEDGE,
  output logic       CP2_NEGEDGE,
  output logic       CP1,
  output logic       CP2,
  output logic [1:0] PHASE,
  output logic       RESETB
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [15:0] CMAX = 16'(RST_CYCLES);

  typedef enum logic [1:0] {
    Q_CP1P = 2'd0,
    Q_CP1N = 2'd1,
    Q_CP2P = 2'd2,
    Q_CP2N = 2'd3
  } phase_t;

  phase_t        phase_q, phase_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [3:0]    en_q, en_d;
  logic          cp1_q, cp1_d;
  logic          cp2_q, cp2_d;
  logic          rb_q, rb_d;
  logic          sync1, sync2;
  logic          ereq;
  logic          tick;

  always_comb begin
    ereq    = ~sync2;
    tick    = ~HOLD && (pre_q == PMAX);
    pre_d   = pre_q;
    phase_d = phase_q;
    en_d    = '0;
    cp1_d   = cp1_q;
    cp2_d   = cp2_q;
    cnt_d   = cnt_q;
    rb_d    = rb_q;

    if (!HOLD)
      pre_d = tick ? '0 : pre_q + 1'b1;

    if (tick) begin
      phase_d = phase_t'(phase_q + 2'd1);
      unique case (phase_d)
        Q_CP1P: begin en_d[0] = 1'b1; cp1_d = 1'b1; end
        Q_CP1N: begin en_d[1] = 1'b1; cp1_d = 1'b0; end
        Q_CP2P: begin en_d[2] = 1'b1; cp2_d = 1'b1; end
        Q_CP2N: begin en_d[3] = 1'b1; cp2_d = 1'b0; end
      endcase
    end

    // release only ever lands on a CP1 rising edge
    if (ereq) begin
      cnt_d = '0;
      rb_d  = 1'b0;
    end else begin
      if (tick && phase_d == Q_CP2N && cnt_q < CMAX)
        cnt_d = cnt_q + 16'd1;
      if (tick && phase_d == Q_CP1P && cnt_q == CMAX)
        rb_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      pre_q   <= '0;
      phase_q <= Q_CP2N;
      en_q    <= '0;
      cp1_q   <= 1'b0;
      cp2_q   <= 1'b0;
      cnt_q   <= '0;
      rb_q    <= 1'b0;
      sync1   <= 1'b1;
      sync2   <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      en_q    <= en_d;
      cp1_q   <= cp1_d;
      cp2_q   <= cp2_d;
      cnt_q   <= cnt_d;
      rb_q    <= rb_d;
      sync1   <= EXT_RESB;
      sync2   <= sync1;
    end
  end

  assign CP1_POSEDGE = en_q[0];
  assign CP1_NEGEDGE = en_q[1];
  assign CP2_POSEDGE = en_q[2];
  assign CP2_NEGEDGE = en_q[3];
  assign CP1         = cp1_q;
  assign CP2         = cp2_q;
  assign PHASE       = phase_q;
  assign RESETB      = rb_q;

endmodule

// File: tb/tb_upd7800_clkgen.sv
// Directed bench for upd7800_clkgen: three divider settings checked
// cycle by cycle against a queued reference model plus boundary probes.
`timescale 1ns/1ps
module tb_upd7800_clkgen;

  logic CLK = 1'b0;
  logic res, res2, hold, extb;
  logic [9:0] o1, o2, o3;

  always #125 CLK = ~CLK;

  upd7800_clkgen #(.DIV(1), .RST_CYCLES(4)) dut1 (
    .CLK(CLK), .RES(res), .HOLD(hold), .EXT_RESB(extb),
    .CP1_POSEDGE(o1[9]), .CP1_NEGEDGE(o1[8]),
    .CP2_POSEDGE(o1[7]), .CP2_NEGEDGE(o1[6]),
    .CP1(o1[5]), .CP2(o1[4]), .PHASE(o1[3:2]), .RESETB(o1[0])
  );

  upd7800_clkgen #(.DIV(2), .RST_CYCLES(4)) dut2 (
    .CLK(CLK), .RES(res2), .HOLD(hold), .EXT_RESB(extb),
    .CP1_POSEDGE(o2[9]), .CP1_NEGEDGE(o2[8]),
    .CP2_POSEDGE(o2[7]), .CP2_NEGEDGE(o2[6]),
    .CP1(o2[5]), .CP2(o2[4]), .PHASE(o2[3:2]), .RESETB(o2[0])
  );

  upd7800_clkgen #(.DIV(3), .RST_CYCLES(2)) dut3 (
    .CLK(CLK), .RES(res), .HOLD(hold), .EXT_RESB(extb),
    .CP1_POSEDGE(o3[9]), .CP1_NEGEDGE(o3[8]),
    .CP2_POSEDGE(o3[7]), .CP2_NEGEDGE(o3[6]),
    .CP1(o3[5]), .CP2(o3[4]), .PHASE(o3[3:2]), .RESETB(o3[0])
  );

  assign o1[1] = 1'b0;
  assign o2[1] = 1'b0;
  assign o3[1] = 1'b0;

  typedef struct {
    int pre;
    int p;
    int cnt;
    bit rb;
    bit s1;
    bit s2;
    bit emit;
  } m_t;

  typedef struct {
    logic [9:0] v1;
    logic [9:0] v2;
    logic [9:0] v3;
  } exp_t;

  m_t    m1, m2, m3;
  exp_t  sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  string tag = "reset";

  function automatic m_t mstep(m_t m, int div, int rst,
                               bit r, bit h, bit eb);
    m_t  n;
    bit  ereq;
    n = m;
    n.emit = 1'b0;
    if (r) begin
      n.pre = 0; n.p = 3; n.cnt = 0; n.rb = 1'b0;
      n.s1 = 1'b1; n.s2 = 1'b1;
      return n;
    end
    ereq = !m.s2;
    n.s2 = m.s1;
    n.s1 = eb;
    if (!h) begin
      if (m.pre == div - 1) begin
        n.pre  = 0;
        n.p    = (m.p + 1) % 4;
        n.emit = 1'b1;
      end else begin
        n.pre = m.pre + 1;
      end
    end
    if (ereq) begin
      n.cnt = 0;
      n.rb  = 1'b0;
    end else begin
      if (n.emit && n.p == 3 && m.cnt < rst) n.cnt = m.cnt + 1;
      if (n.emit && n.p == 0 && m.cnt == rst) n.rb = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [9:0] expv(m_t m);
    logic [1:0] ph;
    ph = 2'(m.p);
    return {m.emit && m.p == 0, m.emit && m.p == 1,
            m.emit && m.p == 2, m.emit && m.p == 3,
            m.p == 0, m.p == 2, ph, 1'b0, m.rb};
  endfunction

  task automatic chk(string t, logic [31:0] obs, logic [31:0] expd);
    vectors++;
    assert (obs === expd) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, expd);
    end
  endtask

  task automatic step();
    exp_t e;
    m1 = mstep(m1, 1, 4, res,  hold, extb);
    m2 = mstep(m2, 2, 4, res2, hold, extb);
    m3 = mstep(m3, 3, 2, res,  hold, extb);
    e.v1 = expv(m1);
    e.v2 = expv(m2);
    e.v3 = expv(m3);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({tag, "/div1"}, 32'(o1), 32'(e.v1));
    chk({tag, "/div2"}, 32'(o2), 32'(e.v2));
    chk({tag, "/div3"}, 32'(o3), 32'(e.v3));
    chk({tag, "/onehot0"},
        {29'd0, $onehot0(o1[9:6]), $onehot0(o2[9:6]), $onehot0(o3[9:6])},
        32'd7);
  endtask

  initial begin
    int rise;
    int n;
    int hi;
    m1 = '{default: 0};
    m2 = '{default: 0};
    m3 = '{default: 0};
    res = 1'b1; res2 = 1'b1; hold = 1'b0; extb = 1'b1;

    repeat (44) step();
    chk("rst_phase", 32'(o1[3:2]), 32'd3);
    chk("rst_resetb", 32'(o1[0]), 32'd0);

    tag = "run";
    res = 1'b0; res2 = 1'b0;
    step();
    chk("first_cp1p", 32'(o1[9]), 32'd1);
    rise = 0;
    for (int i = 2; i <= 24; i++) begin
      step();
      if (o1[0] && rise == 0) rise = i;
    end
    chk("resetb_rise_clk", 32'(rise), 32'd17);

    hi = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o3[5]) hi++;
    end
    chk("div3_cp1_high", 32'(hi), 32'd3);

    tag = "hold";
    n = 0;
    while (!o1[8] && n < 8) begin
      step();
      n++;
    end
    chk("find_cp1n", 32'(o1[8]), 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_no_enable", 32'(o1[9:6]), 32'd0);
    end
    hold = 1'b0;
    step();
    chk("hold_resume_cp2p", 32'(o1[7]), 32'd1);
    repeat (20) step();

    tag = "ext";
    chk("ext_pre_resetb", 32'(o1[0]), 32'd1);
    extb = 1'b0;
    step();
    step();
    extb = 1'b1;
    step();
    chk("ext_resetb_low", 32'(o1[0]), 32'd0);
    n = 0;
    while (!o1[0] && n < 40) begin
      step();
      n++;
    end
    chk("ext_rise_on_cp1p", 32'(o1[9] & o1[0]), 32'd1);
    repeat (8) step();

    tag = "res2";
    n = 0;
    while (!o2[8] && n < 10) begin
      step();
      n++;
    end
    chk("find_div2_cp1n", 32'(o2[8]), 32'd1);
    step();
    chk("div2_phase1", 32'(o2[3:2]), 32'd1);
    res2 = 1'b1;
    step();
    chk("res2_state", 32'(o2), 32'h00C);
    res2 = 1'b0;
    step();
    step();
    chk("res2_restart_cp1p", 32'(o2[9]), 32'd1);
    repeat (10) step();

    tag = "res_over_hold";
    hold = 1'b1;
    res = 1'b1;
    step();
    chk("res_over_hold_phase", 32'(o1[3:2]), 32'd3);
    res = 1'b0;
    hold = 1'b0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
